// File: rtl/cpu_pkg.sv
// Shared pipeline types for the post-decode control path: the per-stage entry
// record, its bubble value and the x0-aware register-match helper.
package cpu_pkg;

  // Upper bounds for the entry fields; instances use the low CTRL_W / REG_AW bits.
  localparam int CTRL_W_MAX = 32;
  localparam int REG_AW_MAX = 8;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_read;
    logic [REG_AW_MAX-1:0] rd;
    logic [CTRL_W_MAX-1:0] ctrl;
  } pipe_entry_t;

  localparam pipe_entry_t PIPE_BUBBLE = '0;

  // x0 is hardwired to zero, so it never matches a producer.
  function automatic logic rd_hit(input logic [REG_AW_MAX-1:0] rd,
                                  input logic [REG_AW_MAX-1:0] rs);
    return (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipe_ctrl_fwd.sv
// Forward-source priority encoder for one source operand: returns k+1 for the
// youngest producing stage k, or 0 when the register file is the source.
module pipe_ctrl_fwd
  import cpu_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic [NUM_STAGES-1:0]            valid_i,
  input  logic [NUM_STAGES-1:0]            reg_write_i,
  input  logic                             load0_i,
  input  logic [NUM_STAGES*REG_AW_MAX-1:0] rd_i,
  input  logic [REG_AW_MAX-1:0]            rs_i,
  output logic [SEL_W-1:0]                 sel_o
);

  // Scan oldest to youngest so the lowest matching stage overrides the rest.
  // A load in stage 0 has no data yet and cannot be a source.
  always_comb begin
    sel_o = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (valid_i[k] && reg_write_i[k] &&
          rd_hit(rd_i[k*REG_AW_MAX +: REG_AW_MAX], rs_i) &&
          !((k == 0) && load0_i)) begin
        sel_o = SEL_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Post-decode pipeline controller: stage registers, hazard stall, forwarding
// selects and retire counter. Define PIPE_CTRL_FWD_EN to enable forwarding.
module pipe_ctrl
  import cpu_pkg::*;
#(
  parameter int  NUM_STAGES = 4,
  parameter int  CTRL_W     = 8,
  parameter int  REG_AW     = 5,
  localparam int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         id_valid_i,
  input  logic [CTRL_W-1:0]            id_ctrl_i,
  input  logic [REG_AW-1:0]            id_rd_i,
  input  logic [REG_AW-1:0]            id_rs1_i,
  input  logic [REG_AW-1:0]            id_rs2_i,
  input  logic                         id_reg_write_i,
  input  logic                         id_mem_read_i,
  input  logic                         flush_i,
  input  logic                         stall_ext_i,
  output logic                         id_ready_o,
  output logic                         hazard_stall_o,
  output logic [NUM_STAGES-1:0]        stage_valid_o,
  output logic [NUM_STAGES*CTRL_W-1:0] stage_ctrl_o,
  output logic [NUM_STAGES*REG_AW-1:0] stage_rd_o,
  output logic [SEL_W-1:0]             fwd_rs1_sel_o,
  output logic [SEL_W-1:0]             fwd_rs2_sel_o,
  output logic [31:0]                  retire_cnt_o
);

  if (NUM_STAGES < 2 || NUM_STAGES > 8 || CTRL_W < 1 || CTRL_W > CTRL_W_MAX ||
      REG_AW < 1 || REG_AW > REG_AW_MAX) begin : g_bad_cfg
    $error("pipe_ctrl: unsupported parameter set");
  end

  pipe_entry_t                      stage_q [NUM_STAGES];
  pipe_entry_t                      id_entry;
  logic [31:0]                      retire_cnt_q;
  logic [REG_AW_MAX-1:0]            rs1_ext, rs2_ext;
  logic                             accept_id;
  logic                             s0_hit1, s0_hit2;
  logic [NUM_STAGES-1:0]            st_valid, st_reg_write;
  logic [NUM_STAGES*REG_AW_MAX-1:0] st_rd;
  logic [SEL_W-1:0]                 sel1, sel2;
  logic [NUM_STAGES-1:0]            unused_bits;

  // ID handshake: id_valid_i offers the decoded instruction; id_ready_o is high
  // exactly in the cycle it is taken into stage 0 on the next rising edge.
  // An offer that is not taken must be re-presented by the decoder.
  assign rs1_ext    = REG_AW_MAX'(id_rs1_i);
  assign rs2_ext    = REG_AW_MAX'(id_rs2_i);
  assign accept_id  = id_valid_i && !flush_i && !hazard_stall_o;
  assign id_ready_o = accept_id && !stall_ext_i;

  always_comb begin
    id_entry           = PIPE_BUBBLE;
    id_entry.valid     = 1'b1;
    id_entry.reg_write = id_reg_write_i;
    id_entry.mem_read  = id_mem_read_i;
    id_entry.rd        = REG_AW_MAX'(id_rd_i);
    id_entry.ctrl      = CTRL_W_MAX'(id_ctrl_i);
  end

  // Flush wins over an external stall, but only stage 0 is squashed then.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        stage_q[k] <= PIPE_BUBBLE;
      end
      retire_cnt_q <= '0;
    end else if (stall_ext_i) begin
      if (flush_i) begin
        stage_q[0] <= PIPE_BUBBLE;
      end
    end else begin
      stage_q[0] <= accept_id ? id_entry : PIPE_BUBBLE;
      for (int k = 1; k < NUM_STAGES; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
      if (stage_q[NUM_STAGES-1].valid) begin
        retire_cnt_q <= retire_cnt_q + 32'd1;
      end
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    assign stage_valid_o[k]               = stage_q[k].valid;
    assign stage_ctrl_o[k*CTRL_W +: CTRL_W] = stage_q[k].ctrl[CTRL_W-1:0];
    assign stage_rd_o[k*REG_AW +: REG_AW]   = stage_q[k].rd[REG_AW-1:0];
    assign st_valid[k]                    = stage_q[k].valid;
    assign st_reg_write[k]                = stage_q[k].reg_write;
    assign st_rd[k*REG_AW_MAX +: REG_AW_MAX] = stage_q[k].rd;
    // Padding bits above CTRL_W and late-stage load flags are never consumed.
    assign unused_bits[k]                 = ^{stage_q[k].ctrl, stage_q[k].mem_read};
  end

  assign retire_cnt_o = retire_cnt_q;

  pipe_ctrl_fwd #(.NUM_STAGES(NUM_STAGES), .SEL_W(SEL_W)) u_fwd_rs1 (
    .valid_i     (st_valid),
    .reg_write_i (st_reg_write),
    .load0_i     (stage_q[0].mem_read),
    .rd_i        (st_rd),
    .rs_i        (rs1_ext),
    .sel_o       (sel1)
  );

  pipe_ctrl_fwd #(.NUM_STAGES(NUM_STAGES), .SEL_W(SEL_W)) u_fwd_rs2 (
    .valid_i     (st_valid),
    .reg_write_i (st_reg_write),
    .load0_i     (stage_q[0].mem_read),
    .rd_i        (st_rd),
    .rs_i        (rs2_ext),
    .sel_o       (sel2)
  );

  assign s0_hit1 = rd_hit(stage_q[0].rd, rs1_ext);
  assign s0_hit2 = rd_hit(stage_q[0].rd, rs2_ext);

`ifdef PIPE_CTRL_FWD_EN
  // Only a load still in stage 0 cannot be bypassed.
  assign hazard_stall_o = id_valid_i && stage_q[0].valid && stage_q[0].mem_read &&
                          (s0_hit1 || s0_hit2);
  assign fwd_rs1_sel_o  = sel1;
  assign fwd_rs2_sel_o  = sel2;
`else
  // Without bypass, wait until every producer has reached the last stage. The
  // encoder skips a stage-0 load, so that case is matched separately.
  assign hazard_stall_o = ((sel1 != '0) && (sel1 < SEL_W'(NUM_STAGES))) ||
                          ((sel2 != '0) && (sel2 < SEL_W'(NUM_STAGES))) ||
                          (stage_q[0].valid && stage_q[0].reg_write &&
                           (s0_hit1 || s0_hit2));
  assign fwd_rs1_sel_o  = '0;
  assign fwd_rs2_sel_o  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; expectations follow the PIPE_CTRL_FWD_EN build
// setting so the same file covers both configurations.
`timescale 1ns/1ps
module tb_pipe_ctrl;
  localparam int NUM_STAGES = 4;
  localparam int CTRL_W     = 8;
  localparam int REG_AW     = 5;
  localparam int SEL_W      = $clog2(NUM_STAGES + 1);
  localparam int W          = CTRL_W + REG_AW;

  logic                         clk_i = 1'b0;
  logic                         rst_ni = 1'b0;
  logic                         id_valid_i = 1'b0;
  logic [CTRL_W-1:0]            id_ctrl_i = '0;
  logic [REG_AW-1:0]            id_rd_i = '0, id_rs1_i = '0, id_rs2_i = '0;
  logic                         id_reg_write_i = 1'b0, id_mem_read_i = 1'b0;
  logic                         flush_i = 1'b0, stall_ext_i = 1'b0;
  logic                         id_ready_o, hazard_stall_o;
  logic [NUM_STAGES-1:0]        stage_valid_o;
  logic [NUM_STAGES*CTRL_W-1:0] stage_ctrl_o;
  logic [NUM_STAGES*REG_AW-1:0] stage_rd_o;
  logic [SEL_W-1:0]             fwd_rs1_sel_o, fwd_rs2_sel_o;
  logic [31:0]                  retire_cnt_o;

  int               vec_cnt = 0;
  int               err_cnt = 0;
  logic [W-1:0]     exp_q[$];
  logic [W-1:0]     exp_e;

  pipe_ctrl #(.NUM_STAGES(NUM_STAGES), .CTRL_W(CTRL_W), .REG_AW(REG_AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .id_valid_i(id_valid_i), .id_ctrl_i(id_ctrl_i),
    .id_rd_i(id_rd_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i),
    .flush_i(flush_i), .stall_ext_i(stall_ext_i), .id_ready_o(id_ready_o),
    .hazard_stall_o(hazard_stall_o), .stage_valid_o(stage_valid_o),
    .stage_ctrl_o(stage_ctrl_o), .stage_rd_o(stage_rd_o),
    .fwd_rs1_sel_o(fwd_rs1_sel_o), .fwd_rs2_sel_o(fwd_rs2_sel_o),
    .retire_cnt_o(retire_cnt_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got %0d vectors, required completion", vec_cnt);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver: apply one ID cycle at the falling edge, outputs settle 1ns later
  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [REG_AW-1:0] rd,
                       input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                       input logic rw, input logic mr, input logic fl, input logic st);
    @(negedge clk_i);
    id_valid_i = v; id_ctrl_i = c; id_rd_i = rd; id_rs1_i = rs1; id_rs2_i = rs2;
    id_reg_write_i = rw; id_mem_read_i = mr; flush_i = fl; stall_ext_i = st;
    #1;
  endtask

  task automatic nop();
    drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) nop();
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    id_valid_i = 1'b0; flush_i = 1'b0; stall_ext_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    // reset values before any clock edge
    #1;
    check("rst_valid", 32'(stage_valid_o), 32'h0);
    check("rst_ctrl", stage_ctrl_o, 32'h0);
    check("rst_rd", 32'(stage_rd_o), 32'h0);
    check("rst_cnt", retire_cnt_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // six independent ALU ops, each reaches stage 3 four edges after acceptance
    for (int c = 0; c < 12; c++) begin
      if (c < 6) begin
        drive(1'b1, CTRL_W'(8'h10 + c), REG_AW'(c + 1), '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("s_ready", 32'(id_ready_o), 32'h1);
        exp_q.push_back({REG_AW'(c + 1), CTRL_W'(8'h10 + c)});
      end else begin
        nop();
      end
      check("s_v0", 32'(stage_valid_o[0]), 32'((c >= 1) && (c <= 6)));
      check("s_v3", 32'(stage_valid_o[3]), 32'((c >= 4) && (c < 10)));
      if (stage_valid_o[3]) begin
        if (exp_q.size() == 0) begin
          check("s_underflow", 32'h1, 32'h0);
        end else begin
          exp_e = exp_q.pop_front();
          check("s_ctrl3", 32'(stage_ctrl_o[3*CTRL_W +: CTRL_W]), 32'(exp_e[CTRL_W-1:0]));
          check("s_rd3", 32'(stage_rd_o[3*REG_AW +: REG_AW]), 32'(exp_e[W-1:CTRL_W]));
        end
      end
    end
    check("s_cnt", retire_cnt_o, 32'd6);
    check("s_qempty", 32'(exp_q.size()), 32'h0);

`ifdef PIPE_CTRL_FWD_EN
    // load-use: one bubble, then the load is bypassed from stage 1
    idle(5);
    drive(1'b1, 8'h50, 5'd5, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("lu_nohz", 32'(hazard_stall_o), 32'h0);
    drive(1'b1, 8'h51, 5'd6, 5'd5, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lu_hz", 32'(hazard_stall_o), 32'h1);
    check("lu_ready", 32'(id_ready_o), 32'h0);
    check("lu_fwd_ld0", 32'(fwd_rs1_sel_o), 32'h0);
    drive(1'b1, 8'h51, 5'd6, 5'd5, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lu_hz_clr", 32'(hazard_stall_o), 32'h0);
    check("lu_ready2", 32'(id_ready_o), 32'h1);
    check("lu_fwd1", 32'(fwd_rs1_sel_o), 32'd2);
    check("lu_bubble", 32'(stage_valid_o[1:0]), 32'b10);
    // ALU producer bypass, youngest-stage priority and x0 exclusion
    drive(1'b1, 8'h52, 5'd7, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("fw_rs1_zero", 32'(fwd_rs1_sel_o), 32'h0);
    drive(1'b1, 8'h53, 5'd9, '0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    check("fw_rs2", 32'(fwd_rs2_sel_o), 32'd1);
    check("fw_alu_nohz", 32'(hazard_stall_o), 32'h0);
    drive(1'b1, 8'h54, 5'd9, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h55, 5'd10, 5'd9, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    check("fw_young", 32'(fwd_rs1_sel_o), 32'd1);
    check("fw_old", 32'(fwd_rs2_sel_o), 32'd3);
    drive(1'b1, 8'h56, 5'd0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h57, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("fw_x0_rs1", 32'(fwd_rs1_sel_o), 32'h0);
    check("fw_x0_rs2", 32'(fwd_rs2_sel_o), 32'h0);
    check("fw_x0_hz", 32'(hazard_stall_o), 32'h0);
`else
    // no bypass: a consumer waits until the producer reaches the last stage
    idle(5);
    drive(1'b1, 8'h70, 5'd7, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("nf_first_hz", 32'(hazard_stall_o), 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h71, 5'd8, 5'd7, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("nf_hz", 32'(hazard_stall_o), 32'h1);
      check("nf_ready", 32'(id_ready_o), 32'h0);
      check("nf_fwd1", 32'(fwd_rs1_sel_o), 32'h0);
      check("nf_fwd2", 32'(fwd_rs2_sel_o), 32'h0);
    end
    drive(1'b1, 8'h71, 5'd8, 5'd7, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("nf_hz_clr", 32'(hazard_stall_o), 32'h0);
    check("nf_ready2", 32'(id_ready_o), 32'h1);
    check("nf_valid", 32'(stage_valid_o), 32'b1000);
    check("nf_ctrl3", 32'(stage_ctrl_o[3*CTRL_W +: CTRL_W]), 32'h70);
    drive(1'b1, 8'h72, 5'd0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h73, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("nf_x0_hz", 32'(hazard_stall_o), 32'h0);
    check("nf_x0_fwd1", 32'(fwd_rs1_sel_o), 32'h0);
`endif

    // external stall for three cycles with a flush in the second
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, CTRL_W'(8'hA0 + i), REG_AW'(11 + i), '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    drive(1'b1, 8'hB0, 5'd20, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("st_ready", 32'(id_ready_o), 32'h0);
    check("st_full", stage_ctrl_o, 32'hA0A1A2A3);
    check("st_valid", 32'(stage_valid_o), 32'b1111);
    drive(1'b1, 8'hB0, 5'd20, '0, '0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("st_fl_ready", 32'(id_ready_o), 32'h0);
    check("st_hold", stage_ctrl_o, 32'hA0A1A2A3);
    drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("st_fl_ctrl", stage_ctrl_o, 32'hA0A1A200);
    check("st_fl_valid", 32'(stage_valid_o), 32'b1110);
    check("st_fl_rd", 32'(stage_rd_o), 32'({5'd11, 5'd12, 5'd13, 5'd0}));
    check("st_cnt_a", retire_cnt_o, 32'h0);
    nop();
    check("st_hold2", stage_ctrl_o, 32'hA0A1A200);
    check("st_cnt_b", retire_cnt_o, 32'h0);
    nop();
    check("st_run_cnt", retire_cnt_o, 32'h1);
    check("st_run_valid", 32'(stage_valid_o), 32'b1100);
    check("st_run_ctrl", stage_ctrl_o, 32'hA1A20000);

    // retire counter wraps from all-ones to zero
    idle(5);
    @(negedge clk_i);
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk_i);
    release dut.retire_cnt_q;
    #1;
    check("w_pre", retire_cnt_o, 32'hFFFF_FFFF);
    drive(1'b1, 8'hC0, 5'd3, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    check("w_in_s3", 32'(stage_valid_o[3]), 32'h1);
    check("w_hold", retire_cnt_o, 32'hFFFF_FFFF);
    nop();
    check("w_wrap", retire_cnt_o, 32'h0);

    // reset mid-stream clears everything without waiting for a clock edge
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, CTRL_W'(8'hD0 + i), REG_AW'(1 + i), '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    check("mr_cnt_pre", retire_cnt_o, 32'h1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("mr_valid", 32'(stage_valid_o), 32'h0);
    check("mr_ctrl", stage_ctrl_o, 32'h0);
    check("mr_rd", 32'(stage_rd_o), 32'h0);
    check("mr_cnt", retire_cnt_o, 32'h0);
    id_valid_i = 1'b0;
    @(negedge clk_i);
    check("mr_hold_valid", 32'(stage_valid_o), 32'h0);
    // first rising edge after release performs the first advance
    rst_ni = 1'b1;
    id_valid_i = 1'b1; id_ctrl_i = 8'hE0; id_rd_i = 5'd4; id_rs1_i = '0; id_rs2_i = '0;
    id_reg_write_i = 1'b1; id_mem_read_i = 1'b0;
    @(negedge clk_i);
    #1;
    check("rel_v0", 32'(stage_valid_o), 32'b0001);
    check("rel_ctrl0", 32'(stage_ctrl_o[CTRL_W-1:0]), 32'hE0);
    check("rel_cnt", retire_cnt_o, 32'h0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
